// File: rtl/adc_rx_pkg.sv
// Shared constants for the adc_rx ADC-path serial receiver.
package adc_rx_pkg;

    localparam int WORD_BITS   = 32;
    localparam int SAMPLE_BITS = 16;
    localparam int FRAME_BCLKS = 64;
    localparam int BIT_IDX_W   = $clog2(FRAME_BCLKS);

endpackage : adc_rx_pkg

// File: rtl/adc_rx_if.sv
// Sample-pair valid/ready link from adc_rx (master) to the downstream DSP (slave).
interface adc_rx_if;

    logic [adc_rx_pkg::SAMPLE_BITS-1:0] left_data;
    logic [adc_rx_pkg::SAMPLE_BITS-1:0] right_data;
    logic                               out_valid;
    logic                               out_ready;

    modport master (
        output left_data,
        output right_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  left_data,
        input  right_data,
        input  out_valid,
        output out_ready
    );

endinterface : adc_rx_if

// File: rtl/adc_rx_clkgen.sv
// Bit-clock / LR-clock generator for the codec master interface.
// fall_evt marks the m_clk edge that takes b_clk from 1 to 0; bit_idx is the
// frame position before that edge's increment.
module adc_rx_clkgen
    import adc_rx_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic                 m_clk,
    input  logic                 reset,
    input  logic                 en,
    output logic                 b_clk,
    output logic                 adc_lr_clk,
    output logic                 fall_evt,
    output logic [BIT_IDX_W-1:0] bit_idx
);

    localparam int                DIV_W       = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF_M1 = DIV_W'(BCLK_DIV / 2 - 1);

    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 b_clk_q, b_clk_d;
    logic                 lr_q, lr_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;

    // Next-state for divider, bit clock, frame position and LR clock.
    always_comb begin
        div_cnt_d = div_cnt_q;
        b_clk_d   = b_clk_q;
        lr_d      = lr_q;
        bit_idx_d = bit_idx_q;
        fall_evt  = 1'b0;
        if (!en) begin
            div_cnt_d = '0;
            b_clk_d   = 1'b0;
            lr_d      = 1'b0;
            bit_idx_d = '1;
        end else begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                b_clk_d   = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_q == DIV_HALF_M1) begin
                    b_clk_d  = 1'b0;
                    // Only a real 1->0 transition counts; the first half
                    // period after enable starts with b_clk already low.
                    fall_evt = b_clk_q;
                end
            end
            if (fall_evt) begin
                bit_idx_d = bit_idx_q + 1'b1;
                // Left half of the frame is indices 0..31.
                lr_d      = ~bit_idx_d[BIT_IDX_W-1];
            end
        end
    end

    // Clock-generator state registers.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            b_clk_q   <= 1'b0;
            lr_q      <= 1'b0;
            bit_idx_q <= '1;
        end else begin
            div_cnt_q <= div_cnt_d;
            b_clk_q   <= b_clk_d;
            lr_q      <= lr_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign b_clk      = b_clk_q;
    assign adc_lr_clk = lr_q;
    assign bit_idx    = bit_idx_q;

endmodule : adc_rx_clkgen

// File: rtl/adc_rx.sv
// adc_rx: WM8731 ADC-path receiver, controller as audio-interface master.
// Generates b_clk/adc_lr_clk, deserializes one 32-bit word per LR frame and
// hands the left/right pair downstream through a one-deep buffer.
// Optional: define ADC_RX_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module adc_rx
    import adc_rx_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic        m_clk,
    input  logic        reset,
    input  logic        en,
    input  logic        adcdat,
    output logic        b_clk,
    output logic        adc_lr_clk,
    adc_rx_if.master    dsp,
    output logic        overrun,
    input  logic        overrun_clr
`ifdef ADC_RX_OVERRUN_CNT_EN
    ,
    output logic [7:0]  overrun_cnt
`endif
);

    logic                   fall_evt;
    logic [BIT_IDX_W-1:0]   bit_idx;

    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic                   word_done_q, word_done_d;
    logic                   valid_q, valid_d;
    logic [SAMPLE_BITS-1:0] left_q, left_d;
    logic [SAMPLE_BITS-1:0] right_q, right_d;
    logic                   overrun_q, overrun_d;
    logic                   load, drop;

    adc_rx_clkgen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .m_clk      (m_clk),
        .reset      (reset),
        .en         (en),
        .b_clk      (b_clk),
        .adc_lr_clk (adc_lr_clk),
        .fall_evt   (fall_evt),
        .bit_idx    (bit_idx)
    );

    // Capture: sample adcdat MSB-first on b_clk falls during the left half.
    // No synchronizer: adcdat changes on b_clk rise, half a bit period earlier.
    always_comb begin
        shift_d     = shift_q;
        word_done_d = 1'b0;
        if (!en) begin
            shift_d = '0;
        end else if (fall_evt && !bit_idx[BIT_IDX_W-1]) begin
            // Bit 31-k equals the bitwise inverse of k over five bits.
            shift_d[~bit_idx[BIT_IDX_W-2:0]] = adcdat;
            word_done_d = (bit_idx == BIT_IDX_W'(WORD_BITS - 1));
        end
    end

    // One-deep output buffer and sticky overrun flag.
    always_comb begin
        load      = word_done_q && (!valid_q || dsp.out_ready);
        drop      = word_done_q && valid_q && !dsp.out_ready;
        valid_d   = valid_q;
        left_d    = left_q;
        right_d   = right_q;
        overrun_d = overrun_q;
        if (load) begin
            valid_d = 1'b1;
            left_d  = shift_q[WORD_BITS-1:SAMPLE_BITS];
            right_d = shift_q[SAMPLE_BITS-1:0];
        end else if (dsp.out_ready) begin
            valid_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Datapath and handshake registers.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            shift_q     <= '0;
            word_done_q <= 1'b0;
            valid_q     <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            word_done_q <= word_done_d;
            valid_q     <= valid_d;
            left_q      <= left_d;
            right_q     <= right_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dsp.out_valid  = valid_q;
    assign dsp.left_data  = left_q;
    assign dsp.right_data = right_q;
    assign overrun        = overrun_q;

`ifdef ADC_RX_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    // Dropped-word counter; a clear coinciding with a drop leaves a count of one.
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (overrun_clr) begin
            ovr_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    // Dropped-word counter register.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            ovr_cnt_q <= 8'd0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign overrun_cnt = ovr_cnt_q;
`endif

endmodule : adc_rx
